// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC feeder.
//   DATA_W         - operand width of weights and activations
//   ACC_W          - PE result width (must match the PE accumulator)
//   feeder_state_t - sequencer FSM states
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 22;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_ISSUE    = 3'd2,
    S_DRAIN    = 3'd3,
    S_WAIT_RES = 3'd4,
    S_DONE     = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/mac_feeder_addrgen.sv
// mac_feeder_addrgen: row/element counters and memory address generation.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   load                - latch config, restart at row 0 / element 0
//   base_w, base_a      - first weight / activation address
//   vec_len, num_vec    - elements per row (L), number of rows (N)
//   elem_clr, elem_step - clear / advance the element counter
//   row_next            - advance to the next row
//   w_addr, a_addr      - current weight / activation read address
//   elem_last           - current element is the last of the row
//   row_last, row_idx   - current row is the last one, current row number
module mac_feeder_addrgen #(
  parameter int AW = 10,
  parameter int LW = 10,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] base_w,
  input  logic [AW-1:0] base_a,
  input  logic [LW-1:0] vec_len,
  input  logic [VW-1:0] num_vec,
  input  logic          elem_clr,
  input  logic          elem_step,
  input  logic          row_next,
  output logic [AW-1:0] w_addr,
  output logic [AW-1:0] a_addr,
  output logic          elem_last,
  output logic          row_last,
  output logic [VW-1:0] row_idx
);

  localparam logic [LW-1:0] ONE_L = LW'(1);
  localparam logic [VW-1:0] ONE_V = VW'(1);

  logic [AW-1:0] base_a_r;
  logic [AW-1:0] wptr_r;   // base_w + r*L, kept as a running sum so no multiplier is needed
  logic [LW-1:0] len_r;
  logic [VW-1:0] num_r;
  logic [LW-1:0] elem_r;
  logic [VW-1:0] row_r;

  // Config latch, element counter and row/weight-pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_a_r <= {AW{1'b0}};
      wptr_r   <= {AW{1'b0}};
      len_r    <= {LW{1'b0}};
      num_r    <= {VW{1'b0}};
      elem_r   <= {LW{1'b0}};
      row_r    <= {VW{1'b0}};
    end else if (load) begin
      base_a_r <= base_a;
      wptr_r   <= base_w;
      len_r    <= vec_len;
      num_r    <= num_vec;
      elem_r   <= {LW{1'b0}};
      row_r    <= {VW{1'b0}};
    end else begin
      if (elem_clr) begin
        elem_r <= {LW{1'b0}};
      end else if (elem_step) begin
        elem_r <= elem_r + ONE_L;
      end
      if (row_next) begin
        // AW-bit sums wrap naturally modulo 2^AW
        wptr_r <= wptr_r + AW'(len_r);
        row_r  <= row_r + ONE_V;
      end
    end
  end

  assign w_addr    = wptr_r + AW'(elem_r);
  assign a_addr    = base_a_r + AW'(elem_r);
  assign elem_last = (elem_r == (len_r - ONE_L));
  assign row_last  = (row_r == (num_r - ONE_V));
  assign row_idx   = row_r;

endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: sequences one matrix-vector product through a MAC PE.
// For each row: clear the PE, stream L weight/activation pairs (pe_acc on
// the last), wait for the PE result and hand it downstream on valid/ready.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   start, base_w, base_a,
//   vec_len, num_vec                - launch and job config (latched in IDLE)
//   busy, done                      - not-idle flag, end-of-job pulse
//   w_rd_*, a_rd_*                  - weight/activation memories (1-cycle latency)
//   pe_*                            - PE controls, operands and result
//   res_valid/ready/data/idx/last   - result handshake
module mac_feeder
  import mac_pkg::*;
#(
  parameter int AW = 10,
  parameter int LW = 10,
  parameter int VW = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AW-1:0]            base_w,
  input  logic [AW-1:0]            base_a,
  input  logic [LW-1:0]            vec_len,
  input  logic [VW-1:0]            num_vec,
  output logic                     busy,
  output logic                     done,
  output logic                     w_rd_en,
  output logic [AW-1:0]            w_rd_addr,
  input  logic signed [DATA_W-1:0] w_rd_data,
  output logic                     a_rd_en,
  output logic [AW-1:0]            a_rd_addr,
  input  logic signed [DATA_W-1:0] a_rd_data,
  output logic                     pe_en,
  output logic                     pe_data_valid,
  output logic                     pe_reset,
  output logic                     pe_acc,
  output logic signed [DATA_W-1:0] pe_weight,
  output logic signed [DATA_W-1:0] pe_activation,
  input  logic                     pe_output_valid,
  input  logic signed [ACC_W-1:0]  pe_output_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_data,
  output logic [VW-1:0]            res_idx,
  output logic                     res_last
);

  feeder_state_t state_r, state_s;

  logic load_s, elem_clr_s, elem_step_s, row_next_s;
  logic rd_en_s, pe_en_s, pe_reset_s, capture_s;
  logic elem_last_s, row_last_s;
  logic [VW-1:0] row_idx_s;

  logic vld_q_r, last_q_r, done_r;
  logic res_valid_r, res_last_r;
  logic signed [ACC_W-1:0] res_data_r;
  logic [VW-1:0] res_idx_r;

  mac_feeder_addrgen #(.AW(AW), .LW(LW), .VW(VW)) u_addrgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .base_w    (base_w),
    .base_a    (base_a),
    .vec_len   (vec_len),
    .num_vec   (num_vec),
    .elem_clr  (elem_clr_s),
    .elem_step (elem_step_s),
    .row_next  (row_next_s),
    .w_addr    (w_rd_addr),
    .a_addr    (a_rd_addr),
    .elem_last (elem_last_s),
    .row_last  (row_last_s),
    .row_idx   (row_idx_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    elem_clr_s  = 1'b0;
    elem_step_s = 1'b0;
    row_next_s  = 1'b0;
    rd_en_s     = 1'b0;
    pe_en_s     = 1'b0;
    pe_reset_s  = 1'b0;
    // a new result may only overwrite the holding register once it is free
    capture_s   = (state_r == S_WAIT_RES) && pe_output_valid &&
                  (!res_valid_r || res_ready);
    case (state_r)
      S_IDLE: begin
        if (start) begin
          load_s = 1'b1;
          if ((vec_len == {LW{1'b0}}) || (num_vec == {VW{1'b0}})) begin
            state_s = S_DONE;
          end else begin
            state_s = S_CLEAR;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        pe_en_s    = 1'b1;
        pe_reset_s = 1'b1;
        elem_clr_s = 1'b1;
        state_s    = S_ISSUE;
      end
      S_ISSUE: begin
        pe_en_s     = 1'b1;
        rd_en_s     = 1'b1;
        elem_step_s = 1'b1;
        if (elem_last_s) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // last read data reaches the PE this cycle
        pe_en_s = 1'b1;
        state_s = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (capture_s) begin
          if (row_last_s) begin
            state_s = S_DONE;
          end else begin
            row_next_s = 1'b1;
            state_s    = S_CLEAR;
          end
        end else begin
          state_s = S_WAIT_RES;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Read-strobe / last-flag delay aligning PE strobes with read data, plus done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q_r  <= 1'b0;
      last_q_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      vld_q_r  <= rd_en_s;
      last_q_r <= rd_en_s & elem_last_s;
      done_r   <= (state_r == S_DONE);
    end
  end

  // Result holding register; a capture takes priority over a handshake drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= {ACC_W{1'b0}};
      res_idx_r   <= {VW{1'b0}};
      res_last_r  <= 1'b0;
    end else if (capture_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= pe_output_result;
      res_idx_r   <= row_idx_s;
      res_last_r  <= row_last_s;
    end else if (res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

  assign busy          = (state_r != S_IDLE);
  assign done          = done_r;
  assign w_rd_en       = rd_en_s;
  assign a_rd_en       = rd_en_s;
  assign pe_en         = pe_en_s;
  assign pe_reset      = pe_reset_s;
  assign pe_data_valid = vld_q_r;
  assign pe_acc        = vld_q_r & last_q_r;
  assign pe_weight     = vld_q_r ? w_rd_data : {DATA_W{1'b0}};
  assign pe_activation = vld_q_r ? a_rd_data : {DATA_W{1'b0}};
  assign res_valid     = res_valid_r;
  assign res_data      = res_data_r;
  assign res_idx       = res_idx_r;
  assign res_last      = res_last_r;

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed bench for mac_feeder with memory and PE models
// and a result scoreboard.
module tb_mac_feeder;

  localparam int AW = 4;
  localparam int LW = 10;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic rst_n, start, res_ready;
  logic [AW-1:0] base_w, base_a;
  logic [LW-1:0] vec_len;
  logic [VW-1:0] num_vec;
  logic busy, done, w_rd_en, a_rd_en;
  logic [AW-1:0] w_rd_addr, a_rd_addr;
  logic signed [7:0] w_rd_data = 8'sd0;
  logic signed [7:0] a_rd_data = 8'sd0;
  logic pe_en, pe_data_valid, pe_reset, pe_acc;
  logic signed [7:0] pe_weight, pe_activation;
  logic pe_output_valid = 1'b0;
  logic signed [21:0] pe_output_result = 22'sd0;
  logic res_valid, res_last;
  logic signed [21:0] res_data;
  logic [VW-1:0] res_idx;

  mac_feeder #(.AW(AW), .LW(LW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_w(base_w), .base_a(base_a), .vec_len(vec_len), .num_vec(num_vec),
    .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .pe_en(pe_en), .pe_data_valid(pe_data_valid), .pe_reset(pe_reset), .pe_acc(pe_acc),
    .pe_weight(pe_weight), .pe_activation(pe_activation),
    .pe_output_valid(pe_output_valid), .pe_output_result(pe_output_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int act_cnt = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic signed [21:0] data;
    logic [VW-1:0]      idx;
    logic               last;
  } exp_t;

  exp_t sb_q[$];
  int   addr_q[$];

  logic signed [7:0] w_mem [16];
  logic signed [7:0] a_mem [16];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read memories
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
  end

  // behavioural PE: clear, accumulate, present sum one cycle after pe_acc; hold while !pe_en
  logic signed [21:0] pe_sum = 22'sd0;
  logic signed [21:0] pw, pa, prod;
  assign pw   = 22'(pe_weight);
  assign pa   = 22'(pe_activation);
  assign prod = pw * pa;
  always @(posedge clk) begin
    if (pe_en) begin
      if (pe_reset) begin
        pe_sum          <= 22'sd0;
        pe_output_valid <= 1'b0;
      end else if (pe_data_valid) begin
        pe_sum           <= pe_acc ? 22'sd0 : pe_sum + prod;
        pe_output_result <= pe_sum + prod;
        pe_output_valid  <= pe_acc;
      end
    end
  end

  // monitor: scoreboard pops, hold-stability, activity and address logging
  logic               hold_p = 1'b0;
  logic signed [21:0] data_p = 22'sd0;
  logic [VW-1:0]      idx_p  = 8'd0;
  logic               last_p = 1'b0;
  always @(negedge clk) begin
    if (hold_p) begin
      check("hold_data", res_data, data_p);
      check("hold_idx", res_idx, idx_p);
      check("hold_last", res_last, last_p);
    end
    hold_p <= res_valid && !res_ready;
    data_p <= res_data;
    idx_p  <= res_idx;
    last_p <= res_last;
    if (res_valid && res_ready) begin
      check("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        check("res_data", res_data, sb_q[0].data);
        check("res_idx", res_idx, sb_q[0].idx);
        check("res_last", res_last, sb_q[0].last);
        sb_q.delete(0);
      end
    end
    if (w_rd_en || a_rd_en || pe_en || res_valid) act_cnt <= act_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (w_rd_en) addr_q.push_back(int'(w_rd_addr));
  end

  task automatic push_exp(input int data, input int idx, input logic last);
    exp_t e;
    e.data = 22'(data);
    e.idx  = VW'(idx);
    e.last = last;
    sb_q.push_back(e);
  endtask

  task automatic fill(input int wb, input int w0, input int w1, input int w2, input int w3,
                      input int ab, input int a0, input int a1, input int a2, input int a3);
    w_mem[(wb + 0) % 16] = 8'(w0); w_mem[(wb + 1) % 16] = 8'(w1);
    w_mem[(wb + 2) % 16] = 8'(w2); w_mem[(wb + 3) % 16] = 8'(w3);
    a_mem[(ab + 0) % 16] = 8'(a0); a_mem[(ab + 1) % 16] = 8'(a1);
    a_mem[(ab + 2) % 16] = 8'(a2); a_mem[(ab + 3) % 16] = 8'(a3);
  endtask

  task automatic launch(input int bw, input int ba, input int l, input int n);
    @(posedge clk); #1;
    base_w = AW'(bw); base_a = AW'(ba); vec_len = LW'(l); num_vec = VW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  // returns the cycle index (CLEAR = 1) of the done pulse and of the first res_valid
  task automatic wait_done(input int limit, output int at, output int rv_at);
    at = -1;
    rv_at = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (res_valid && rv_at < 0) rv_at = cyc - t0 + 1;
      if (done) begin
        at = cyc - t0 + 1;
        break;
      end
    end
    check("done_seen", at >= 0, 1);
  endtask

  int at, rv_at, act0, dn0;
  int exp_addr[4] = '{14, 15, 0, 1};

  initial begin
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b1;
    base_w = 4'd0; base_a = 4'd0; vec_len = 10'd0; num_vec = 8'd0;
    for (int k = 0; k < 16; k++) begin
      w_mem[k] = 8'sd0;
      a_mem[k] = 8'sd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, w_rd_en, a_rd_en, pe_en, pe_data_valid, pe_reset, pe_acc,
                            res_valid, res_last, w_rd_addr, a_rd_addr, pe_weight, pe_activation,
                            res_data, res_idx}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // dot product with exact latency
    fill(0, 3, 3, -2, 5, 8, 1, 2, 4, -1);
    push_exp(-4, 0, 1'b1);
    launch(0, 8, 4, 1);
    wait_done(40, at, rv_at);
    check("dot_res_valid_cycle", rv_at, 8);
    check("dot_done_cycle", at, 9);
    check("dot_drained", sb_q.size(), 0);
    @(negedge clk);
    check("dot_busy_after", busy, 0);

    // back-pressure: three rows, result 0 held 10 cycles
    w_mem[0] = 8'sd1; w_mem[1] = 8'sd2; w_mem[2] = 8'sd3;
    w_mem[3] = 8'sd4; w_mem[4] = 8'sd5; w_mem[5] = 8'sd6;
    a_mem[8] = 8'sd7; a_mem[9] = -8'sd1;
    push_exp(5, 0, 1'b0); push_exp(17, 1, 1'b0); push_exp(29, 2, 1'b1);
    res_ready = 1'b0;
    launch(0, 8, 2, 3);
    for (int k = 0; k < 50 && !res_valid; k++) @(negedge clk);
    check("bp_first_valid", res_valid, 1);
    repeat (10) @(negedge clk);
    check("bp_stalled_idx", res_idx, 0);
    check("bp_stalled_data", res_data, 5);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done(100, at, rv_at);
    check("bp_drained", sb_q.size(), 0);

    // degenerate configs
    act0 = act_cnt;
    launch(0, 8, 0, 2);
    wait_done(10, at, rv_at);
    check("len0_done_cycle", at, 2);
    check("len0_no_activity", act_cnt - act0, 0);
    act0 = act_cnt;
    launch(0, 8, 4, 0);
    wait_done(10, at, rv_at);
    check("num0_done_cycle", at, 2);
    check("num0_no_activity", act_cnt - act0, 0);

    // zero and extreme operands
    fill(0, 0, 0, 0, 0, 8, 9, -9, 100, -100);
    push_exp(0, 0, 1'b1);
    launch(0, 8, 4, 1);
    wait_done(40, at, rv_at);
    check("zero_drained", sb_q.size(), 0);
    fill(0, -128, -128, -128, -128, 8, 127, 127, 127, 127);
    push_exp(-65024, 0, 1'b1);
    launch(0, 8, 4, 1);
    wait_done(40, at, rv_at);
    check("extreme_drained", sb_q.size(), 0);

    // weight address wrap
    fill(14, 1, 2, 3, 4, 8, 1, 1, 1, 1);
    push_exp(10, 0, 1'b1);
    addr_q.delete();
    launch(14, 8, 4, 1);
    wait_done(40, at, rv_at);
    check("wrap_drained", sb_q.size(), 0);
    check("wrap_addr_count", addr_q.size(), 4);
    for (int k = 0; k < 4 && k < addr_q.size(); k++) check("wrap_addr", addr_q[k], exp_addr[k]);

    // reset during ISSUE: no result, no done
    fill(0, 1, 1, 1, 1, 8, 1, 1, 1, 1);
    launch(0, 8, 4, 1);
    repeat (2) @(negedge clk);
    check("rst_in_issue", w_rd_en, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {busy, done, w_rd_en, a_rd_en, pe_en, pe_data_valid, pe_reset, pe_acc,
                              res_valid, res_last, w_rd_addr, a_rd_addr, pe_weight, pe_activation,
                              res_data, res_idx}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    dn0 = done_cnt;
    repeat (15) @(negedge clk);
    check("rst_no_done", done_cnt - dn0, 0);
    fill(0, 2, 2, 2, 2, 8, 1, 1, 1, 1);
    push_exp(8, 0, 1'b1);
    launch(0, 8, 4, 1);
    wait_done(40, at, rv_at);
    check("post_rst_done_cycle", at, 9);
    check("post_rst_drained", sb_q.size(), 0);

    // start while busy is ignored
    fill(0, 1, 1, 1, 1, 8, 2, 2, 2, 2);
    push_exp(8, 0, 1'b1);
    launch(0, 8, 4, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    base_w = 4'd5; vec_len = 10'd2; num_vec = 8'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(60, at, rv_at);
    check("busy_start_done_cycle", at, 9);
    repeat (3) @(negedge clk);
    check("busy_start_idle", busy, 0);
    check("busy_start_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
